// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory port between the fetch unit (master) and instruction memory (slave).
// Handshake: imem_req stays high with imem_addr stable until a cycle where imem_ready is high; that cycle's imem_rdata is the word for imem_addr.
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch stage: fetches one instruction, holds it through EXEC, selects the next PC,
// counts retired instructions and halts on a misaligned taken-branch target.
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  pc_fetch_unit_if.master   imem,
  input  logic              PCsrc,
  input  logic [XLEN-1:0]   ImmExt,
  input  logic              stall,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [XLEN-1:0]   PC,
  output logic [XLEN-1:0]   PCplus4,
  output logic [31:0]       retire_count,
  output logic              misalign_err,
  output logic [1:0]        fsm_state
);
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] tgt_pc;
  logic            tgt_misaligned;

  // Both sums wrap naturally at XLEN bits; ImmExt is two's complement.
  assign seq_pc         = PC + XLEN'(4);
  assign tgt_pc         = PC + ImmExt;
  assign tgt_misaligned = (tgt_pc[1:0] != 2'b00);

  assign PCplus4        = seq_pc;
  assign imem.imem_req  = (state == FETCH) && !rst;
  assign imem.imem_addr = PC;
  assign fsm_state      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      PC           <= RESET_PC;
      instr        <= '0;
      instr_valid  <= 1'b0;
      retire_count <= '0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem.imem_ready) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            // A misaligned taken branch does not retire and leaves PC on the branch.
            if (PCsrc && tgt_misaligned) begin
              misalign_err <= 1'b1;
              state        <= HALT;
            end else begin
              PC           <= PCsrc ? tgt_pc : seq_pc;
              retire_count <= retire_count + 32'd1;
              state        <= FETCH;
            end
          end
        end
        HALT: begin
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule
